inv_mixcolumns: RTL

INV_MIXCOLUMNS -- requirements
Module: inv_mixcolumns

---
 rtl/inv_mixcolumns.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/inv_mixcolumns.sv
// ---------------------------------------------------------------------------
// inv_mixcolumns
//   Applies the AES InvMixColumns transform to a 128-bit state. A block is
//   captured in IDLE. It is transformed COLS_PER_CYCLE columns per clock in
//   BUSY. It is held in DONE until the consumer takes it.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     producer offers a block on `state`
//   in_ready     block can accept a new input (high only in IDLE)
//   state        128-bit AES state; byte i = state[127-8i -: 8],
//                column c = bytes 4c..4c+3 (column 0 = state[127:96])
//   out          transformed state, same byte/column layout
//   out_valid    `out` holds a completed result (high only in DONE)
//   out_ready    consumer takes `out`
//   dbg_state_o  current FSM encoding (IDLE=0, BUSY=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready/out_valid depend only on registered state, never on
// the other side's valid/ready. Once raised, out_valid and `out` stay
// unchanged until the transfer completes. A block is never accepted on the
// same edge that a result is handed off.
//
// COLS_PER_CYCLE must be 1, 2 or 4.
// ---------------------------------------------------------------------------
module inv_mixcolumns #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state,
    output logic [127:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e        fsm_q;
    logic [1:0]  col_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [31:0] src_q [4];
    logic [31:0] res_q [4];
    logic [31:0] res_d [4];
    logic        last_step;

    // Multiply by x (0x02) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the inverse MixColumns matrix. 0e/0b/0d/09 are
    // built from the x2/x4/x8 chain of each input byte.
    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2[i] = xt(a[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Result columns updated by this BUSY step: col_q and the following
    // COLS_PER_CYCLE-1 columns. All other columns keep their value.
    always_comb begin
        res_d = res_q;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            res_d[col_q + 2'(j)] = inv_col(src_q[col_q + 2'(j)]);
        end
    end

    // This step covers column 3, so the block completes on this edge.
    assign last_step = (col_q + 2'(COLS_PER_CYCLE - 1)) == 2'd3;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            col_q       <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                src_q[i] <= 32'h0;
                res_q[i] <= 32'h0;
            end
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 4; i++) begin
                            src_q[i] <= state[127-32*i -: 32];
                        end
                        col_q      <= 2'd0;
                        fsm_q      <= BUSY;
                        in_ready_q <= 1'b0;
                    end
                end
                BUSY: begin
                    res_q <= res_d;
                    // COLS_PER_CYCLE=4 truncates to 0, so the counter wraps.
                    col_q <= col_q + 2'(COLS_PER_CYCLE);
                    if (last_step) begin
                        fsm_q       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_q       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    col_q       <= 2'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out         = {res_q[0], res_q[1], res_q[2], res_q[3]};
    assign dbg_state_o = fsm_q;

endmodule
